standoff_round_ctrl: RTL and testbench

//  Sequences one two-player standoff game: countdown, draw window, result hold, game over.

---
 rtl/standoff_round_ctrl_if.sv | 24 ++
 rtl/standoff_round_ctrl.sv | 102 ++++++++++
 tb/tb_standoff_round_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/standoff_round_ctrl_if.sv
// standoff_round_ctrl_if: button inputs and game status outputs of the standoff round controller
//  master drives start/p1_fire/p2_fire and observes status; slave is the controller side.
interface standoff_round_ctrl_if #(parameter int LW = 2);
  logic          start;
  logic          p1_fire;
  logic          p2_fire;
  logic          draw_go;
  logic [LW-1:0] p1_lives;
  logic [LW-1:0] p2_lives;
  logic          p1_hit;
  logic          p2_hit;
  logic          round_done;
  logic          game_over;
  logic [1:0]    winner;
  logic [2:0]    state_o;
  modport master (
    output start, p1_fire, p2_fire,
    input  draw_go, p1_lives, p2_lives, p1_hit, p2_hit, round_done, game_over, winner, state_o
  );
  modport slave (
    input  start, p1_fire, p2_fire,
    output draw_go, p1_lives, p2_lives, p1_hit, p2_hit, round_done, game_over, winner, state_o
  );
endinterface

// File: rtl/standoff_round_ctrl.sv
// standoff_round_ctrl: sequences a two-player standoff game (countdown, draw, result, over)
//  clk, rst_n (async active-low)
//  bus.start/p1_fire/p2_fire : 1-cycle input pulses
//  bus.draw_go, p1/p2_lives, p1/p2_hit, round_done, game_over, winner, state_o : registered status
module standoff_round_ctrl #(
  parameter int LIVES         = 3,
  parameter int COUNT_CYCLES  = 8,
  parameter int DRAW_CYCLES   = 16,
  parameter int RESULT_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  standoff_round_ctrl_if.slave bus
);
  localparam int LW   = $clog2(LIVES + 1);
  localparam int MAXC = (COUNT_CYCLES > DRAW_CYCLES) ?
                        ((COUNT_CYCLES > RESULT_CYCLES) ? COUNT_CYCLES : RESULT_CYCLES) :
                        ((DRAW_CYCLES > RESULT_CYCLES) ? DRAW_CYCLES : RESULT_CYCLES);
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] T_CNT = TW'(COUNT_CYCLES - 1);
  localparam logic [TW-1:0] T_DRW = TW'(DRAW_CYCLES - 1);
  localparam logic [TW-1:0] T_RES = TW'(RESULT_CYCLES - 1);
  localparam logic [LW-1:0] L_MAX = LW'(LIVES);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, DRAW, RESULT, OVER} state_t;
  state_t        st, st_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [LW-1:0] l1, l2, l1_n, l2_n;
  logic          h1_n, h2_n, reload;
  wire           f1 = bus.p1_fire;
  wire           f2 = bus.p2_fire;
  always_comb begin
    st_n   = st;
    tmr_n  = (tmr == '0) ? '0 : tmr - 1'b1;
    h1_n   = 1'b0;
    h2_n   = 1'b0;
    reload = 1'b0;
    case (st)
      IDLE: if (bus.start) begin
        st_n  = COUNTDOWN;
        tmr_n = T_CNT;
      end
      COUNTDOWN: if (f1 || f2) begin
        // a fire before the cue costs the firing player(s) a life
        st_n  = RESULT;
        tmr_n = T_RES;
        h1_n  = f1 && l1 != '0;
        h2_n  = f2 && l2 != '0;
      end else if (tmr == '0) begin
        st_n  = DRAW;
        tmr_n = T_DRW;
      end
      DRAW: if (f1 || f2 || tmr == '0) begin
        // the slower player loses; simultaneous fire or timeout costs nobody
        st_n  = RESULT;
        tmr_n = T_RES;
        h1_n  = f2 && !f1 && l1 != '0;
        h2_n  = f1 && !f2 && l2 != '0;
      end
      RESULT: if (tmr == '0) begin
        st_n  = (l1 == '0 || l2 == '0) ? OVER : COUNTDOWN;
        tmr_n = (l1 == '0 || l2 == '0) ? '0 : T_CNT;
      end
      OVER: if (bus.start) begin
        st_n   = COUNTDOWN;
        tmr_n  = T_CNT;
        reload = 1'b1;
      end
      default: st_n = IDLE;
    endcase
    l1_n = reload ? L_MAX : l1 - LW'(h1_n);
    l2_n = reload ? L_MAX : l2 - LW'(h2_n);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      tmr            <= '0;
      l1             <= L_MAX;
      l2             <= L_MAX;
      bus.draw_go    <= 1'b0;
      bus.p1_hit     <= 1'b0;
      bus.p2_hit     <= 1'b0;
      bus.round_done <= 1'b0;
      bus.game_over  <= 1'b0;
      bus.winner     <= 2'b00;
    end else begin
      st             <= st_n;
      tmr            <= tmr_n;
      l1             <= l1_n;
      l2             <= l2_n;
      bus.draw_go    <= st_n == DRAW;
      bus.p1_hit     <= h1_n;
      bus.p2_hit     <= h2_n;
      // last RESULT cycle is the one whose timer reads zero
      bus.round_done <= st_n == RESULT && tmr_n == '0;
      bus.game_over  <= st_n == OVER;
      bus.winner     <= (st_n == OVER) ? {l1_n == '0, l2_n == '0} : 2'b00;
    end
  end
  assign bus.p1_lives = l1;
  assign bus.p2_lives = l2;
  assign bus.state_o  = st;
endmodule

// File: tb/tb_standoff_round_ctrl.sv
// tb_standoff_round_ctrl: random stimulus checked against a phase/elapsed-cycle game model
module tb_standoff_round_ctrl;
  localparam int LIVES = 3, CC = 4, DC = 8, RC = 2, LW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  standoff_round_ctrl_if #(.LW(LW)) bus();
  standoff_round_ctrl #(
    .LIVES(LIVES), .COUNT_CYCLES(CC), .DRAW_CYCLES(DC), .RESULT_CYCLES(RC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int ph, cnt, l1, l2;
  bit h1, h2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    ph = 0; cnt = 0; l1 = LIVES; l2 = LIVES; h1 = 0; h2 = 0;
  endtask
  task automatic check_all();
    chk("state", 32'(bus.state_o), ph);
    chk("draw_go", 32'(bus.draw_go), ph == 2);
    chk("p1_lives", 32'(bus.p1_lives), l1);
    chk("p2_lives", 32'(bus.p2_lives), l2);
    chk("p1_hit", 32'(bus.p1_hit), ph == 3 && cnt == 0 && h1);
    chk("p2_hit", 32'(bus.p2_hit), ph == 3 && cnt == 0 && h2);
    chk("round_done", 32'(bus.round_done), ph == 3 && cnt == RC - 1);
    chk("game_over", 32'(bus.game_over), ph == 4);
    chk("winner", 32'(bus.winner), ph == 4 ? 2 * (l1 == 0) + (l2 == 0) : 0);
  endtask
  task automatic lose(input bit a, input bit b);
    h1 = a && l1 > 0; h2 = b && l2 > 0;
    l1 -= h1; l2 -= h2;
    ph = 3; cnt = 0;
  endtask
  task automatic model_step(input bit s, input bit f1, input bit f2);
    case (ph)
      0: if (s) begin ph = 1; cnt = 0; end
      1: if (f1 || f2) lose(f1, f2);
         else if (cnt == CC - 1) begin ph = 2; cnt = 0; end
         else cnt++;
      2: if (f1 || f2) lose(f2 && !f1, f1 && !f2);
         else if (cnt == DC - 1) lose(0, 0);
         else cnt++;
      3: if (cnt == RC - 1) begin ph = (l1 == 0 || l2 == 0) ? 4 : 1; cnt = 0; end
         else cnt++;
      default: if (s) begin ph = 1; cnt = 0; l1 = LIVES; l2 = LIVES; end
    endcase
  endtask
  initial begin
    bit s, f1, f2;
    int r;
    bus.start = 0; bus.p1_fire = 0; bus.p2_fire = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #11 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      check_all();
      if (ph != 0 && $urandom_range(0, 199) == 0) begin
        bus.start = 0; bus.p1_fire = 0; bus.p2_fire = 0;
        #1 rst_n = 1'b0;
        #1 model_reset();
        chk("async_rst_state", 32'(bus.state_o), 0);
        chk("async_rst_lives", 32'({bus.p1_lives, bus.p2_lives}), {2'(LIVES), 2'(LIVES)});
        check_all();
        #1 rst_n = 1'b1;
        continue;
      end
      r  = $urandom_range(0, 19);
      s  = $urandom_range(0, 3) == 0;
      f1 = r == 0 || r == 2;
      f2 = r == 1 || r == 2;
      bus.start = s; bus.p1_fire = f1; bus.p2_fire = f2;
      model_step(s, f1, f2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
